// File: rtl/cabin_ctrl_pkg.sv
// Shared types and default constants for the cabin call-button debouncer.
package cabin_ctrl_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_LONG_CYCLES     = 1000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } dbn_state_e;

  typedef struct packed {
    logic level;
    logic press;
    logic call_en;
    logic call_d;
  } dbn_out_t;

  // One counter serves both the stable-sample count and the long-press age.
  function automatic int cnt_width(input int deb, input int lng);
    int top;
    top = (deb > lng) ? deb : lng;
    return $clog2(top + 1);
  endfunction

endpackage

// File: rtl/cabin_input_sync.sv
// Multi-flop synchronizer bringing the raw call button into the clk domain.
module cabin_input_sync
  import cabin_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/cabin_call_debounce.sv
// Cabin call-button debouncer with press pulse and call-light write port.
// Optional long-press pulse enabled by defining CABIN_CALL_LONG_PRESS_EN.
module cabin_call_debounce
  import cabin_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic clear,
  output logic btn_level,
  output logic press_pulse,
  output logic call_en,
  output logic call_d,
  output logic long_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);

  localparam logic [CW-1:0] ONE =
    CW'(1);
  localparam logic [CW-1:0] DEB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

`ifdef CABIN_CALL_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST =
    CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] LONG_SAT =
    CW'(LONG_CYCLES);
  logic long_q;
`endif

  logic       s;
  dbn_state_e state_q;
  logic [CW-1:0] cnt_q;
  dbn_out_t   out_q;

  cabin_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (btn_raw),
    .q      (s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
`ifdef CABIN_CALL_LONG_PRESS_EN
      long_q  <= 1'b0;
`endif
    end else begin
      out_q.press   <= 1'b0;
      out_q.call_en <= clear;
      out_q.call_d  <= 1'b0;
`ifdef CABIN_CALL_LONG_PRESS_EN
      long_q        <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (s) begin
            state_q <= WAIT_PRESS;
            cnt_q   <= ONE;
          end
        end
        WAIT_PRESS: begin
          if (!s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            // Press wins over a coincident clear.
            state_q       <= PRESSED;
            cnt_q         <= '0;
            out_q.level   <= 1'b1;
            out_q.press   <= 1'b1;
            out_q.call_en <= 1'b1;
            out_q.call_d  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= ONE;
          end
`ifdef CABIN_CALL_LONG_PRESS_EN
          else if (cnt_q == LONG_LAST) begin
            cnt_q  <= LONG_SAT;
            long_q <= 1'b1;
          end else if (cnt_q != LONG_SAT) begin
            cnt_q <= cnt_q + ONE;
          end
`endif
        end
        WAIT_RELEASE: begin
          if (s) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_q.level <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign btn_level   = out_q.level;
  assign press_pulse = out_q.press;
  assign call_en     = out_q.call_en;
  assign call_d      = out_q.call_d;

`ifdef CABIN_CALL_LONG_PRESS_EN
  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_cabin_call_debounce.sv
// Directed and random checks of cabin_call_debounce against a sample-history model.
module tb_cabin_call_debounce;

  localparam int D  = 16;
  localparam int SS = 2;
  localparam int L  = 5;
`ifdef CABIN_CALL_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_raw = 1'b0;
  logic clear = 1'b0;
  logic btn_level, press_pulse;
  logic call_en, call_d, long_pulse;

  int total = 0;
  int bad = 0;

  cabin_call_debounce #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (SS),
    .LONG_CYCLES    (L)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .clear      (clear),
    .btn_level  (btn_level),
    .press_pulse(press_pulse),
    .call_en    (call_en),
    .call_d     (call_d),
    .long_pulse (long_pulse)
  );

  always #5 clk = ~clk;

  // Model: s is btn_raw delayed SS edges; level flips once the
  // last D samples of s all disagree with the current level.
  logic pipe[$];
  logic hist[$];
  logic m_level, m_press, m_en, m_d, m_long;
  logic prev_s, run_lvl;
  int   run;

  task automatic model_reset();
    pipe = {};
    for (int i = 0; i < SS; i++) pipe.push_back(1'b0);
    hist = {};
    m_level = 0; m_press = 0; m_en = 0;
    m_d = 0; m_long = 0;
    prev_s = 0; run_lvl = 0; run = 0;
  endtask

  task automatic model_step();
    logic s;
    logic flip;
    int target;
    s = pipe.pop_front();
    pipe.push_back(btn_raw);
    hist.push_back(s);
    if (hist.size() > D) void'(hist.pop_front());
    if (s) begin
      if (!prev_s) run_lvl = m_level;
      run++;
    end else begin
      run = 0;
    end
    prev_s = s;
    flip = (hist.size() == D);
    foreach (hist[i]) if (hist[i] == m_level) flip = 0;
    m_press = flip && !m_level;
    if (flip) m_level = !m_level;
    m_en = m_press | clear;
    m_d  = m_press;
    target = run_lvl ? (L + 1) : (D + L);
    m_long = LONG_EN && m_level && s && (run == target);
  endtask

  task automatic chk(input string tag,
                     input logic got,
                     input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("level", btn_level, m_level);
    chk("press", press_pulse, m_press);
    chk("call_en", call_en, m_en);
    chk("call_d", call_d, m_d);
    chk("long", long_pulse, m_long);
  endtask

  // Entered and left at a negedge.
  task automatic tick(input logic raw, input logic clr);
    btn_raw = raw;
    clear = clr;
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic assert_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_level"}, btn_level, 1'b0);
    chk({tag, "_press"}, press_pulse, 1'b0);
    chk({tag, "_en"}, call_en, 1'b0);
    chk({tag, "_d"}, call_d, 1'b0);
    chk({tag, "_long"}, long_pulse, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int pe, le, lc;
    logic seen;
    model_reset();
    #1;
    chk("rst_level", btn_level, 1'b0);
    chk("rst_en", call_en, 1'b0);
    @(negedge clk);
    tick(1'b0, 1'b0);
    reset_n = 1'b1;

    // Held press: level rises on edge 18.
    for (int i = 1; i <= 17; i++) tick(1'b1, 1'b0);
    chk("e17_level", btn_level, 1'b0);
    tick(1'b1, 1'b0);
    chk("e18_level", btn_level, 1'b1);
    chk("e18_press", press_pulse, 1'b1);
    chk("e18_en", call_en, 1'b1);
    chk("e18_d", call_d, 1'b1);
    tick(1'b1, 1'b0);
    chk("e19_press", press_pulse, 1'b0);

    // Crew clear while held, at edge 30.
    for (int i = 20; i <= 29; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("clr_en", call_en, 1'b1);
    chk("clr_d", call_d, 1'b0);
    chk("clr_press", press_pulse, 1'b0);
    tick(1'b1, 1'b0);
    chk("clr_en_off", call_en, 1'b0);

    // Release latency matches press latency.
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick(1'b0, 1'b0);
      if (!btn_level) n = i;
    end
    chk("rel_latency", n == 18, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);

    // Short glitch must be invisible.
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      tick(i < 10, 1'b0);
      seen |= btn_level | press_pulse | call_en;
      seen |= call_d | long_pulse;
    end
    chk("glitch_quiet", seen, 1'b0);

    // Clear coinciding with the press pulse.
    for (int i = 1; i <= 17; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("coin_press", press_pulse, 1'b1);
    chk("coin_en", call_en, 1'b1);
    chk("coin_d", call_d, 1'b1);
    for (int i = 0; i < 24; i++) tick(1'b0, 1'b0);

    // Reset mid-debounce, re-debounce from scratch.
    for (int i = 1; i <= 9; i++) tick(1'b1, 1'b0);
    assert_reset("rst_mid");
    tick(1'b1, 1'b0);
    reset_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick(1'b1, 1'b0);
      if (press_pulse) n = i;
    end
    chk("rerun_latency", n == 18, 1'b1);

    // Reset while the level is high.
    tick(1'b1, 1'b0);
    assert_reset("rst_hi");
    tick(1'b0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);

    // Long hold: one long pulse L cycles after the level rises.
    pe = 0; le = 0; lc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1, 1'b0);
      if (press_pulse) pe = i;
      if (long_pulse) begin
        lc++;
        le = i;
      end
    end
    chk("long_count", lc == (LONG_EN ? 1 : 0), 1'b1);
    if (LONG_EN) chk("long_delay", (le - pe) == L, 1'b1);
    for (int i = 0; i < 24; i++) tick(1'b0, 1'b0);

    // Random segments against the model.
    for (int seg = 0; seg < 160; seg++) begin
      logic v;
      int len;
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        len = $urandom_range(16, 45);
      else
        len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++)
        tick(v, $urandom_range(0, 9) == 0);
      if (seg == 80) begin
        assert_reset("rst_rand");
        tick(v, 1'b0);
        reset_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cabin_call_debounce.md
CABIN_CALL_DEBOUNCE -- requirements
Module: cabin_call_debounce

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a level change; legal range >= 2.
REQ-002 Parameter: SYNC_STAGES, 2, metastability flops on btn_raw; legal range >= 2.
REQ-003 Parameter: LONG_CYCLES, 1000, cycles in PRESSED before the long-press pulse; legal range >= 1.
REQ-004 Port: clk  input  1  single clock, rising-edge active.
REQ-005 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: btn_raw  input  1  asynchronous passenger call button, 1 = pressed.
REQ-007 Port: clear  input  1  synchronous crew-cancel request, sampled every cycle.
REQ-008 Port: btn_level  output  1  debounced button level, registered.
REQ-009 Port: press_pulse  output  1  one-cycle pulse on an accepted press.
REQ-010 Port: call_en  output  1  write enable for the downstream 1-bit call-light register.
REQ-011 Port: call_d  output  1  data for the downstream call-light register.
REQ-012 Port: long_pulse  output  1  one-cycle pulse on a long press.

Function
REQ-013 btn_raw SHALL pass through a SYNC_STAGES flop chain; all later logic SHALL use only the chain output s.
REQ-014 The FSM SHALL have four states: IDLE (level 0), WAIT_PRESS, PRESSED (level 1), WAIT_RELEASE.
REQ-015 IDLE SHALL move to WAIT_PRESS when s=1, with the stable counter loaded to 1.
REQ-016 WAIT_PRESS SHALL return to IDLE when s=0 and clear the counter; otherwise it SHALL increment, and it SHALL enter PRESSED when the count reaches DEBOUNCE_CYCLES.
REQ-017 PRESSED and WAIT_RELEASE SHALL mirror REQ-015 and REQ-016 with s=0 as the candidate level and PRESSED as the fallback state.
REQ-018 For btn_raw held steady, btn_level SHALL rise exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples btn_raw=1 (18 with defaults); release latency SHALL be identical.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no change on any output.
REQ-020 press_pulse SHALL be high for exactly the one cycle in which btn_level goes 0->1; release SHALL produce no pulse.
REQ-021 call_en SHALL equal press_pulse OR clear; call_d SHALL equal press_pulse; both SHALL be registered alongside press_pulse.
REQ-022 If clear and press_pulse coincide, press SHALL win: call_en=1 and call_d=1.
REQ-023 The counter width SHALL be $clog2 of max(DEBOUNCE_CYCLES, LONG_CYCLES)+1, and the counter SHALL never wrap.

Reset
REQ-024 Asserting reset_n=0 SHALL immediately force state IDLE, the counter to 0, the sync chain to 0, and every output to 0.
REQ-025 Reset asserted mid-debounce or mid-press SHALL abort with no pulse; a button still held after reset release SHALL be re-debounced from scratch (full REQ-018 latency).

Configuration
REQ-026 Macro CABIN_CALL_LONG_PRESS_EN: when defined, a counter running in PRESSED (cleared on entry) SHALL pulse long_pulse for one cycle after LONG_CYCLES cycles, saturate, and not repeat until the state re-enters PRESSED.
REQ-027 When CABIN_CALL_LONG_PRESS_EN is undefined, long_pulse SHALL be constant 0 and no long-press counter logic SHALL be synthesized.

Structure
REQ-028 The state enum typedef and default constants (DEBOUNCE_CYCLES, SYNC_STAGES, LONG_CYCLES) SHALL reside in the shared package cabin_ctrl_pkg.
REQ-029 The synchronizer SHALL be one sub-module, cabin_input_sync (parameter SYNC_STAGES, ports clk, reset_n, d, q).

Verification
REQ-030 Defaults; btn_raw 0->1 held -> btn_level=1, press_pulse=1, call_en=1, call_d=1 on edge 18; press_pulse=0 on edge 19.
REQ-031 Defaults; btn_raw high for 10 cycles then low -> all outputs remain 0 throughout.
REQ-032 Button held; clear=1 for one cycle at edge 30 -> call_en=1, call_d=0 for that cycle only; press_pulse stays 0.
REQ-033 clear=1 on the press_pulse cycle -> call_en=1, call_d=1.
REQ-034 reset_n low at edge 10 of a press, released at edge 12 with button held -> outputs 0 immediately; press_pulse at 18 edges after release.
REQ-035 Macro defined, LONG_CYCLES=5, button held 40 cycles -> exactly one long_pulse, 5 cycles after btn_level rises; macro undefined -> long_pulse never 1.
